// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped countdown timer occupying the Dev0 slot behind the system
//   bridge. Software programs PRESET and CTRL; the timer loads PRESET into
//   COUNT, counts down to zero, raises an interrupt flag and then either
//   stops (one-shot) or reloads (auto-reload).
//
// Ports
//   clk    in   system clock, all state updates on the rising edge
//   reset  in   synchronous active-high reset
//   Addr   in   byte address; only Addr[3:2] is decoded (device select is
//               done by the bridge)
//   WE     in   write strobe, already qualified by the bridge hit
//   Din    in   write data
//   Dout   out  combinational read data of the addressed register
//   IRQ    out  interrupt request (irq_flag gated by CTRL.IM)
//
// Register map (Addr[3:2])
//   0 CTRL   R/W  [0] EN, [2:1] MODE, [3] IM; upper bits read 0
//   1 PRESET R/W
//   2 COUNT  RO
//   3 reserved, reads 0
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Addr,
    input  logic             WE,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             IRQ
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             ctrl_en;
    logic [1:0]       ctrl_mode;
    logic             ctrl_im;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             irq_flag;

    logic             wr_ctrl;
    logic             wr_preset;

    // FSM action strobes
    logic             do_load;
    logic             do_dec;
    logic             do_fire;
    logic             do_stop;
    logic             do_rearm;

    // Address bits outside [3:2] are decoded by the bridge, not here.
    logic             unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    assign wr_ctrl   = WE && (Addr[3:2] == 2'd0);
    assign wr_preset = WE && (Addr[3:2] == 2'd1);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, evaluated on pre-edge register values
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ctrl_en) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_CNT;
            S_CNT: begin
                if (!ctrl_en) begin
                    state_nxt = S_IDLE;
                end else if (count > ONE) begin
                    state_nxt = S_CNT;
                end else begin
                    state_nxt = S_INT;
                end
            end
            S_INT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: datapath action strobes
    always_comb begin
        do_load  = 1'b0;
        do_dec   = 1'b0;
        do_fire  = 1'b0;
        do_stop  = 1'b0;
        do_rearm = 1'b0;
        case (state)
            S_LOAD: do_load = 1'b1;
            S_CNT: begin
                if (ctrl_en) begin
                    // COUNT of 0 or 1 fires directly so it never wraps below 0
                    if (count > ONE) begin
                        do_dec = 1'b1;
                    end else begin
                        do_fire = 1'b1;
                    end
                end
            end
            S_INT: begin
                // Only MODE=01 reloads; 00 and 1x both behave as one-shot
                if (ctrl_mode == 2'b01) begin
                    do_rearm = 1'b1;
                end else begin
                    do_stop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= '0;
            count     <= '0;
            irq_flag  <= 1'b0;
        end else begin
            // A software CTRL write overrides the hardware EN clear
            if (wr_ctrl) begin
                ctrl_en   <= Din[0];
                ctrl_mode <= Din[2:1];
                ctrl_im   <= Din[3];
            end else if (do_stop) begin
                ctrl_en <= 1'b0;
            end

            if (wr_preset) begin
                preset <= Din;
            end

            if (do_load) begin
                count <= preset;
            end else if (do_dec) begin
                count <= count - ONE;
            end else if (do_fire) begin
                count <= '0;
            end

            // The hardware set beats a simultaneous software clear
            if (do_fire) begin
                irq_flag <= 1'b1;
            end else if (wr_ctrl || wr_preset || do_rearm) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Read mux
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0: Dout = {{(WIDTH-4){1'b0}}, ctrl_im, ctrl_mode, ctrl_en};
            2'd1: Dout = preset;
            2'd2: Dout = count;
            default: Dout = '0;
        endcase
    end

    assign IRQ = irq_flag & ctrl_im;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit countdown timer on the device side of the system bridge: Dev0 slot.
- Receives the bridge-qualified address, write enable and write data.
- Returns read data on Dout, which feeds the bridge Dev0RD input.
- Drives IRQ, which feeds the bridge Dev0Irq input and ends up on HWInt[0].

Parameters:
- WIDTH, 32, width of PRESET, COUNT, Din and Dout.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Addr  input  32  byte address from CPU. Only Addr[3:2] is decoded; the bridge has already done device select.
- WE  input  1  write strobe, already qualified by the bridge hit.
- Din  input  WIDTH  write data.
- Dout  output  WIDTH  combinational read data for the currently addressed register.
- IRQ  output  1  interrupt request to the bridge.

Behaviour:
- Register map (Addr[3:2]):
  - 0 = CTRL (R/W). Bits: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] read 0, writes ignored.
  - 1 = PRESET (R/W).
  - 2 = COUNT (read-only; writes ignored).
  - 3 = reserved (reads 0, writes ignored).
- MODE values:
  - 00 = one-shot.
  - 01 = auto-reload.
  - 1x = treated as 00.
- Reset (reset=1 at edge): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Therefore IRQ=0 and Dout reflects zeros.
- Write: when WE=1 at an edge, the addressed register updates at that edge. A write to CTRL or PRESET also clears irq_flag at the same edge.
- Read: Dout is purely combinational from Addr[3:2] and current register values; zero latency.
- FSM, evaluated with register values before the edge:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT:
    - EN=0 -> IDLE; COUNT holds its value.
    - else if COUNT > 1: COUNT <= COUNT-1.
    - else (COUNT is 0 or 1): COUNT <= 0, irq_flag <= 1, -> INT.
  - INT:
    - MODE one-shot: CTRL.EN <= 0, -> IDLE; irq_flag stays 1 until software writes CTRL or PRESET.
    - MODE auto-reload: irq_flag <= 0, -> IDLE. EN is still 1, so the FSM reloads.
- IRQ = irq_flag & CTRL.IM. Combinational from registers, so masking takes effect the cycle after the CTRL write.
- Timing:
  - From the edge that writes EN=1 (state IDLE), IRQ rises after edge PRESET+2.
  - Auto-reload period is PRESET+3 cycles.
  - In auto-reload mode IRQ is high exactly one cycle per period.
- Boundary cases:
  - PRESET=0 or 1: the first CNT cycle fires; COUNT never wraps below 0.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - Simultaneous software CTRL write and hardware EN clear in INT: the software write wins, and irq_flag is cleared.
  - Simultaneous irq_flag set (CNT -> INT) and software CTRL/PRESET write: the set wins.
  - Reset mid-count: all state returns to reset values at that edge.

Test Plan:
- Reset check:
  - Stimulus: assert reset 2 cycles, then read Addr 0x0/0x4/0x8/0xC.
  - Required: Dout = 0 for every read; IRQ = 0.
- One-shot:
  - Stimulus: PRESET=3, then CTRL=0x9 (EN, IM, mode 0).
  - Required: COUNT reads 3,2,1,0 on successive cycles after LOAD. IRQ rises 5 edges after the CTRL write and stays high. CTRL reads 0x8 afterward. Writing PRESET=5 drops IRQ the next cycle.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Required: IRQ one-cycle pulses every 5 cycles, for at least 3 periods. COUNT sequence 2,1,0 repeats.
- Mask and stop:
  - Stimulus: PRESET=4, CTRL=0x1 (IM=0).
  - Required: irq_flag sets but IRQ stays 0.
  - Follow-on stimulus: separately, clear EN mid-count at COUNT=2.
  - Required: COUNT holds 2 and the state returns to IDLE.
- Edge values:
  - Stimulus: PRESET=0 with CTRL=0x9.
  - Required: IRQ after 3 edges; COUNT=0.
  - Stimulus: PRESET=0xFFFFFFFF.
  - Required: first decrement gives 0xFFFFFFFE.
  - Stimulus: write to COUNT or Addr 0xC.
  - Required: no effect on any register.
- Collision:
  - Stimulus: write CTRL=0x9 on the same edge the one-shot FSM leaves INT.
  - Required: EN stays 1 and irq_flag clears.
  - Stimulus: assert reset while in CNT.
  - Required: all registers 0 on the next cycle.
